imem_boot_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU.
- Receives a program image as a stream of 32-bit words over a valid/ready handshake.
- Writes the image into the instruction memory write port.
- Holds the CPU in reset while loading, then releases reset and drives the CPU start_i input.
- Replaces bench-side memory preloading with a synthesizable, checksum-verified load path.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/ldr_checksum.sv | 24 ++
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the boot-time memory loaders.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

  localparam int DEF_DEPTH  = 256;
  localparam int DEF_DATA_W = 32;

  // Header length field is one bit wider than the word address so N==DEPTH fits.
  function automatic int hdr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  localparam int HDR_W = hdr_width($clog2(DEF_DEPTH));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } ldr_state_t;

endpackage

// File: rtl/ldr_checksum.sv
// Modular (2^W) running sum of accepted words, with synchronous clear and add-enable.
// Latency: sum_o reflects an added word one cycle after add_i.
// Backpressure: none; the caller gates add_i with its own handshake.
module ldr_checksum
  import imem_loader_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  // Accumulate; clear wins over add, carries out of bit W-1 are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i)     sum_o <= '0;
    else if (clr_i) sum_o <= '0;
    else if (add_i) sum_o <= sum_o + data_i;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a header/payload/checksum word stream into instruction memory, then releases the CPU.
// Latency: imem write one cycle after each payload handshake; cpu_rst_o rises on the checksum edge, start_o one cycle later.
// Backpressure: ready_o high only in HDR/LOAD/CHECK; valid_i gaps stall the load indefinitely.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_data_o,
  output logic              cpu_rst_o,
  output logic              start_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int CNT_W = hdr_width(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

  ldr_state_t        state, state_d;
  logic [CNT_W-1:0]  count, count_d, count_inc;
  logic [CNT_W-1:0]  nwords, nwords_d;
  logic [CNT_W-1:0]  hdr_n;
  logic [DATA_W-1:0] sum, wdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic              xfer, sum_clr, sum_add;
  logic              ready_d, we_d, cpu_rst_d, start_d, err_d;

  assign xfer      = valid_i && ready_o;
  assign hdr_n     = data_i[CNT_W-1:0];
  assign count_inc = count + 1'b1;

  ldr_checksum #(.W(DATA_W)) u_sum (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (sum_clr),
    .add_i  (sum_add),
    .data_i (data_i),
    .sum_o  (sum)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_d   = state;
    count_d   = count;
    nwords_d  = nwords;
    we_d      = 1'b0;
    addr_d    = imem_addr_o;
    wdata_d   = imem_data_o;
    cpu_rst_d = cpu_rst_o;
    start_d   = start_o;
    err_d     = err_o;
    sum_clr   = 1'b0;
    sum_add   = 1'b0;
    case (state)
      IDLE: begin
        if (load_req_i) begin
          state_d = HDR;
          count_d = '0;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_n == '0 || hdr_n > DEPTH_N) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d  = LOAD;
            nwords_d = hdr_n;
            count_d  = '0;
            sum_clr  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = count[ADDR_W-1:0];
          wdata_d = data_i;
          sum_add = 1'b1;
          count_d = count_inc;
          if (count_inc == nwords) state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer) begin
          if (data_i == sum) begin
            state_d   = RUN;
            cpu_rst_d = 1'b1;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        // A reload pulls the CPU back into reset on the same edge it is requested.
        if (load_req_i) begin
          state_d   = HDR;
          cpu_rst_d = 1'b0;
          start_d   = 1'b0;
          count_d   = '0;
        end else begin
          start_d = 1'b1;
        end
      end
      ERROR: begin
        cpu_rst_d = 1'b0;
        start_d   = 1'b0;
        if (load_req_i) begin
          state_d = HDR;
          err_d   = 1'b0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == HDR) || (state_d == LOAD) || (state_d == CHECK);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ready_o     <= 1'b0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      cpu_rst_o   <= 1'b0;
      start_o     <= 1'b0;
      err_o       <= 1'b0;
      words_o     <= '0;
      count       <= '0;
      nwords      <= '0;
    end else begin
      ready_o     <= ready_d;
      imem_we_o   <= we_d;
      imem_addr_o <= addr_d;
      imem_data_o <= wdata_d;
      cpu_rst_o   <= cpu_rst_d;
      start_o     <= start_d;
      err_o       <= err_d;
      words_o     <= count_d;
      count       <= count_d;
      nwords      <= nwords_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Waits on ready_o are bounded; an expired wait counts as a failure.
module tb_imem_boot_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              load_req_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [DATA_W-1:0] imem_data_o;
  logic              cpu_rst_o;
  logic              start_o;
  logic              err_o;
  logic [HDR_W-1:0]  words_o;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int wr0;

  always #5 clk_i = ~clk_i;

  imem_boot_loader dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_req_i  (load_req_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .cpu_rst_o   (cpu_rst_o),
    .start_o     (start_o),
    .err_o       (err_o),
    .words_o     (words_o)
  );

  // Count write pulses, sampled mid-cycle.
  always @(negedge clk_i) if (imem_we_o === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req();
    load_req_i = 1'b1;
    tick();
    load_req_i = 1'b0;
  endtask

  // Present one word and hold it until the edge on which it is accepted.
  task automatic send(input logic [DATA_W-1:0] w);
    int n;
    n = 0;
    data_i  = w;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("send_rdy", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, "_we"}, imem_we_o, 1'b1);
    chk({tag, "_addr"}, imem_addr_o, a);
    chk({tag, "_data"}, imem_data_o, d);
  endtask

  task automatic good_stream();
    send(32'd3);
    send(32'h00500093);
    send(32'h00A00113);
    send(32'h002081B3);
    send(32'h01108359);
  endtask

  initial begin
    rst_i = 1'b0; load_req_i = 1'b0; valid_i = 1'b0; data_i = '0;
    tick(); tick();
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_we", imem_we_o, 1'b0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_data", imem_data_o, 0);
    chk("rst_cpu_rst", cpu_rst_o, 1'b0);
    chk("rst_start", start_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_words", words_o, 0);

    // Nominal load: 0x00500093 + 0x00A00113 + 0x002081B3 = 0x01108359.
    rst_i = 1'b1;
    tick();
    chk("idle_ready", ready_o, 1'b0);
    req();
    chk("hdr_ready", ready_o, 1'b1);
    send(32'd3);
    chk("hdr_no_wr", imem_we_o, 1'b0);
    send(32'h00500093);
    chk_wr("nom_w0", 8'd0, 32'h00500093);
    chk("nom_words1", words_o, 1);
    send(32'h00A00113);
    chk_wr("nom_w1", 8'd1, 32'h00A00113);
    send(32'h002081B3);
    chk_wr("nom_w2", 8'd2, 32'h002081B3);
    chk("nom_chk_ready", ready_o, 1'b1);
    send(32'h01108359);
    chk("nom_cpu_rst", cpu_rst_o, 1'b1);
    chk("nom_start0", start_o, 1'b0);
    chk("nom_ready0", ready_o, 1'b0);
    chk("nom_no_wr", imem_we_o, 1'b0);
    chk("nom_words", words_o, 3);
    chk("nom_err", err_o, 1'b0);
    tick();
    chk("nom_start1", start_o, 1'b1);
    chk("nom_cpu_rst_hold", cpu_rst_o, 1'b1);
    chk("nom_wr_cnt", wr_cnt, 3);

    // Bad checksum, then recovery with a good stream.
    req();
    chk("rl_cpu_rst", cpu_rst_o, 1'b0);
    chk("rl_start", start_o, 1'b0);
    chk("rl_words", words_o, 0);
    send(32'd3);
    send(32'h00500093);
    send(32'h00A00113);
    send(32'h002081B3);
    send(32'h0110835A);
    chk("bad_ck_err", err_o, 1'b1);
    chk("bad_ck_cpu_rst", cpu_rst_o, 1'b0);
    chk("bad_ck_ready", ready_o, 1'b0);
    tick();
    chk("bad_ck_start", start_o, 1'b0);
    req();
    chk("err_clr", err_o, 1'b0);
    chk("err_rl_ready", ready_o, 1'b1);
    good_stream();
    chk("rec_cpu_rst", cpu_rst_o, 1'b1);
    chk("rec_err", err_o, 1'b0);

    // Bad headers: zero and DEPTH+1, no writes either time.
    wr0 = wr_cnt;
    req();
    send(32'd0);
    chk("hdr0_err", err_o, 1'b1);
    chk("hdr0_ready", ready_o, 1'b0);
    chk("hdr0_cpu_rst", cpu_rst_o, 1'b0);
    req();
    send(32'd257);
    chk("hdr257_err", err_o, 1'b1);
    chk("hdr257_ready", ready_o, 1'b0);
    tick(); tick();
    chk("badhdr_no_wr", wr_cnt, wr0);

    // Bursty N=4 with a load_req during LOAD that must be ignored; 1+2+3+4 = 10.
    req();
    send(32'd4);
    for (int i = 0; i < 4; i++) begin
      send(32'(i + 1));
      chk_wr("burst", 8'(i), 32'(i + 1));
      chk("burst_words", words_o, i + 1);
      load_req_i = (i == 1);
      tick();
      load_req_i = 1'b0;
      chk("burst_gap_we", imem_we_o, 1'b0);
      chk("burst_gap_ready", ready_o, 1'b1);
    end
    send(32'd10);
    chk("burst_cpu_rst", cpu_rst_o, 1'b1);
    chk("burst_err", err_o, 1'b0);
    tick();
    chk("burst_wr_cnt", wr_cnt, wr0 + 4);

    // Modular checksum and header upper bits ignored (N=2); then reload from RUN.
    req();
    send(32'hFFFF0002);
    send(32'hFFFFFFFF);
    chk_wr("wrap_w0", 8'd0, 32'hFFFFFFFF);
    send(32'h00000002);
    chk_wr("wrap_w1", 8'd1, 32'h00000002);
    send(32'h00000001);
    chk("wrap_cpu_rst", cpu_rst_o, 1'b1);
    chk("wrap_err", err_o, 1'b0);
    tick();
    chk("wrap_start", start_o, 1'b1);
    req();
    chk("wrap_rl_cpu_rst", cpu_rst_o, 1'b0);
    chk("wrap_rl_start", start_o, 1'b0);
    chk("wrap_rl_ready", ready_o, 1'b1);
    chk("wrap_rl_words", words_o, 0);

    // Reset after 2 of 5 payload words.
    send(32'd5);
    send(32'h0000000A);
    send(32'h0000000B);
    chk_wr("mid_w1", 8'd1, 32'h0000000B);
    data_i = 32'h0000000C;
    valid_i = 1'b1;
    rst_i = 1'b0;
    tick();
    wr0 = wr_cnt;
    chk("mid_ready", ready_o, 1'b0);
    chk("mid_we", imem_we_o, 1'b0);
    chk("mid_addr", imem_addr_o, 0);
    chk("mid_data", imem_data_o, 0);
    chk("mid_cpu_rst", cpu_rst_o, 1'b0);
    chk("mid_words", words_o, 0);
    tick();
    rst_i = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_ready", ready_o, 1'b0);
    chk("post_rst_no_wr", wr_cnt, wr0);
    chk("post_rst_words", words_o, 0);
    valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
